// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    // Register-file address width used across the core
    localparam int REGISTER_FILE_ADDRESS_LEN = 4;

    // EXE operand mux select encodings
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // SRAM wait tracking states
    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select_unit.sv
// Per-operand forwarding select: MEM result beats WB result, else register file.
module fwd_select_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REGISTER_FILE_ADDRESS_LEN
) (
    input  logic                  fwd_en,
    input  logic [REG_ADDR_W-1:0] exe_src,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_wb_en,
    output logic [1:0]            sel
);

    // Priority compare of the EXE source against the younger producers first
    always_comb begin
        sel = FWD_REG;
        if (fwd_en) begin
            if ((exe_src == mem_dest) && mem_wb_en) begin
                sel = FWD_MEM;
            end else if ((exe_src == wb_dest) && wb_wb_en) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline controller: stall, flush, freeze, forwarding selects,
// stall-cycle performance counter and sticky SRAM timeout flag.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REGISTER_FILE_ADDRESS_LEN,
    parameter int STALL_CNT_W = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fwd_en,
    input  logic [REG_ADDR_W-1:0]  id_src_1,
    input  logic [REG_ADDR_W-1:0]  id_src_2,
    input  logic                   id_two_src,
    input  logic [REG_ADDR_W-1:0]  exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0]  exe_src_1,
    input  logic [REG_ADDR_W-1:0]  exe_src_2,
    input  logic [REG_ADDR_W-1:0]  mem_dest,
    input  logic                   mem_wb_en,
    input  logic [REG_ADDR_W-1:0]  wb_dest,
    input  logic                   wb_wb_en,
    input  logic                   branch_taken,
    input  logic                   mem_busy,
    output logic                   hazard,
    output logic                   flush,
    output logic                   freeze,
    output logic [1:0]             sel_src_1,
    output logic [1:0]             sel_src_2,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   timeout_err
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

    // run_q is cleared asynchronously by reset and set on the first edge
    // after release; it masks every control output so reset takes effect
    // without a clock and release is synchronous.
    logic                   run_q, run_d;
    state_t                 state_q, state_d;
    logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   timeout_q, timeout_d;

    logic       m1, m2, load_use, raw;
    logic [1:0] fwd_sel_1, fwd_sel_2;

    fwd_select_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_1 (
        .fwd_en    (fwd_en),
        .exe_src   (exe_src_1),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_dest   (wb_dest),
        .wb_wb_en  (wb_wb_en),
        .sel       (fwd_sel_1)
    );

    fwd_select_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_2 (
        .fwd_en    (fwd_en),
        .exe_src   (exe_src_2),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_dest   (wb_dest),
        .wb_wb_en  (wb_wb_en),
        .sel       (fwd_sel_2)
    );

    // Hazard detection and prioritised freeze > flush > hazard outputs
    always_comb begin
        m1 = ((id_src_1 == exe_dest) && exe_wb_en) ||
             ((id_src_1 == mem_dest) && mem_wb_en);
        m2 = id_two_src &&
             (((id_src_2 == exe_dest) && exe_wb_en) ||
              ((id_src_2 == mem_dest) && mem_wb_en));
        load_use = exe_mem_r_en && exe_wb_en &&
                   ((id_src_1 == exe_dest) ||
                    (id_two_src && (id_src_2 == exe_dest)));
        raw = fwd_en ? load_use : (m1 || m2);

        freeze    = run_q && mem_busy;
        flush     = run_q && branch_taken && !mem_busy;
        hazard    = run_q && raw && !mem_busy && !branch_taken;
        sel_src_1 = run_q ? fwd_sel_1 : FWD_REG;
        sel_src_2 = run_q ? fwd_sel_2 : FWD_REG;
    end

    // SRAM wait FSM, saturating wait counter, sticky timeout and stall counter
    always_comb begin
        run_d      = 1'b1;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_d    = stall_q;

        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = WAIT;
                    wait_cnt_d = TIMEOUT_W'(1);
                end
            end
            WAIT: begin
                if (freeze) begin
                    if (wait_cnt_q != TIMEOUT_VAL) begin
                        wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        timeout_d = timeout_q || (wait_cnt_d == TIMEOUT_VAL);

        if ((hazard || freeze) && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            state_q    <= RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            run_q      <= run_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_cycles = stall_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fwd_en, id_two_src, exe_wb_en, exe_mem_r_en;
    logic        mem_wb_en, wb_wb_en, branch_taken, mem_busy;
    logic [3:0]  id_src_1, id_src_2, exe_dest, exe_src_1, exe_src_2;
    logic [3:0]  mem_dest, wb_dest;
    logic        hazard, flush, freeze, timeout_err;
    logic [1:0]  sel_src_1, sel_src_2;
    logic [15:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;
    int exp_stall  = 0;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .fwd_en       (fwd_en),
        .id_src_1     (id_src_1),
        .id_src_2     (id_src_2),
        .id_two_src   (id_two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .exe_src_1    (exe_src_1),
        .exe_src_2    (exe_src_2),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .wb_dest      (wb_dest),
        .wb_wb_en     (wb_wb_en),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .hazard       (hazard),
        .flush        (flush),
        .freeze       (freeze),
        .sel_src_1    (sel_src_1),
        .sel_src_2    (sel_src_2),
        .stall_cycles (stall_cycles),
        .timeout_err  (timeout_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Return all inputs to an idle, non-matching pattern
    task automatic applyStimulus();
        fwd_en = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; wb_wb_en = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        id_src_1 = 4'd0; id_src_2 = 4'd0; exe_dest = 4'd15; exe_src_1 = 4'd1;
        exe_src_2 = 4'd2; mem_dest = 4'd14; wb_dest = 4'd13;
    endtask

    // Advance one rising edge and settle just after it
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus();

        // Reset asserted: outputs forced low even with busy SRAM and a raw match
        #1 rst = 1'b0;
        mem_busy = 1'b1; id_src_1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        checkOutput("rst_freeze", freeze, 0);
        checkOutput("rst_hazard", hazard, 0);
        checkOutput("rst_flush", flush, 0);
        checkOutput("rst_sel1", sel_src_1, 0);
        checkOutput("rst_stall", stall_cycles, 0);
        checkOutput("rst_timeout", timeout_err, 0);
        applyStimulus();
        @(negedge clk) rst = 1'b1;
        stepClk();
        checkOutput("post_rst_stall", stall_cycles, 0);

        // No forwarding: EXE destination match on src1 stalls
        exe_dest = 4'd3; exe_wb_en = 1'b1; id_src_1 = 4'd3;
        #1 checkOutput("raw_src1_hazard", hazard, 1);
        stepClk(); exp_stall++;
        checkOutput("raw_src1_stall", stall_cycles, exp_stall);
        id_src_1 = 4'd9; id_src_2 = 4'd3; id_two_src = 1'b0;
        #1 checkOutput("src2_unqual_hazard", hazard, 0);
        stepClk();
        checkOutput("src2_unqual_stall", stall_cycles, exp_stall);
        id_two_src = 1'b1;
        #1 checkOutput("src2_qual_hazard", hazard, 1);
        stepClk(); exp_stall++;
        id_src_2 = 4'd0; id_two_src = 1'b0; mem_dest = 4'd9; mem_wb_en = 1'b1;
        #1 checkOutput("raw_mem_hazard", hazard, 1);
        stepClk(); exp_stall++;
        checkOutput("raw_stall2", stall_cycles, exp_stall);
        applyStimulus();

        // Forwarding on: only load-use stalls
        fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd5;
        id_src_2 = 4'd5; id_two_src = 1'b1;
        #1 checkOutput("load_use_hazard", hazard, 1);
        stepClk(); exp_stall++;
        exe_mem_r_en = 1'b0;
        #1 checkOutput("alu_use_hazard", hazard, 0);
        stepClk();
        exe_wb_en = 1'b0; exe_dest = 4'd15; exe_src_2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1;
        id_src_2 = 4'd0; id_two_src = 1'b0;
        #1 checkOutput("fwd_sel2_mem", sel_src_2, 1);
        checkOutput("fwd_stall", stall_cycles, exp_stall);

        // MEM beats WB, WB next, then register file
        exe_src_1 = 4'd7; mem_dest = 4'd7; wb_dest = 4'd7; mem_wb_en = 1'b1; wb_wb_en = 1'b1;
        #1 checkOutput("fwd_sel1_mem", sel_src_1, 1);
        mem_wb_en = 1'b0;
        #1 checkOutput("fwd_sel1_wb", sel_src_1, 2);
        wb_wb_en = 1'b0;
        #1 checkOutput("fwd_sel1_reg", sel_src_1, 0);
        wb_wb_en = 1'b1; fwd_en = 1'b0;
        #1 checkOutput("fwd_disabled", sel_src_1, 0);
        applyStimulus();

        // Branch beats raw hazard; flush does not count as a stall
        id_src_1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; branch_taken = 1'b1;
        #1 checkOutput("br_flush", flush, 1);
        checkOutput("br_hazard", hazard, 0);
        stepClk();
        checkOutput("br_stall", stall_cycles, exp_stall);
        applyStimulus();

        // Branch during freeze: flush deferred until SRAM ready
        branch_taken = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("brfrz_freeze", freeze, 1);
            checkOutput("brfrz_flush", flush, 0);
            stepClk(); exp_stall++;
        end
        mem_busy = 1'b0;
        #1 checkOutput("brfrz_release_flush", flush, 1);
        checkOutput("brfrz_release_freeze", freeze, 0);
        checkOutput("brfrz_stall", stall_cycles, exp_stall);
        stepClk();
        applyStimulus();

        // SRAM timeout after 64 consecutive busy cycles, sticky afterwards
        mem_busy = 1'b1;
        repeat (63) begin
            stepClk(); exp_stall++;
        end
        checkOutput("timeout_63", timeout_err, 0);
        stepClk(); exp_stall++;
        checkOutput("timeout_64", timeout_err, 1);
        checkOutput("timeout_freeze", freeze, 1);
        mem_busy = 1'b0;
        stepClk();
        stepClk();
        checkOutput("timeout_sticky", timeout_err, 1);
        checkOutput("timeout_stall", stall_cycles, exp_stall);

        // Asynchronous reset mid-WAIT
        mem_busy = 1'b1;
        stepClk();
        stepClk();
        #1 rst = 1'b0;
        #1;
        checkOutput("arst_freeze", freeze, 0);
        checkOutput("arst_stall", stall_cycles, 0);
        checkOutput("arst_timeout", timeout_err, 0);
        @(negedge clk) rst = 1'b1;
        #1 checkOutput("release_freeze_pre", freeze, 0);
        stepClk();
        checkOutput("release_freeze_post", freeze, 1);
        checkOutput("release_stall0", stall_cycles, 0);
        stepClk();
        checkOutput("release_stall1", stall_cycles, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage ARM core.
- Sequences the IF/ID/EXE/MEM/WB registers by generating the ID-stage `hazard` (stall), the `flush` of IF/ID and ID/EXE registers on taken branches, and a global `freeze` while the data SRAM is busy.
- Also drives forwarding selects for the EXE-stage operand muxes.
- Keeps a saturating stall-cycle counter and a sticky SRAM-timeout error.

Parameters:
- REG_ADDR_W, 4, register-file address width
- STALL_CNT_W, 16, width of stall-cycle performance counter
- MEM_TIMEOUT, 64, consecutive `mem_busy` cycles that set `timeout_err`
- TIMEOUT_W, 8, width of the SRAM wait counter (must hold MEM_TIMEOUT)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- fwd_en  input  1  forwarding enable (quasi-static configuration)
- id_src_1  input  REG_ADDR_W  Rn of instruction in ID
- id_src_2  input  REG_ADDR_W  Rm/Rd-store source of instruction in ID
- id_two_src  input  1  ID instruction really reads id_src_2
- exe_dest  input  REG_ADDR_W  destination of instruction in EXE
- exe_wb_en  input  1  EXE instruction writes back
- exe_mem_r_en  input  1  EXE instruction is a load
- exe_src_1  input  REG_ADDR_W  Rn of instruction in EXE (for forwarding)
- exe_src_2  input  REG_ADDR_W  Rm of instruction in EXE
- mem_dest  input  REG_ADDR_W  destination in MEM
- mem_wb_en  input  1  MEM instruction writes back
- wb_dest  input  REG_ADDR_W  destination in WB
- wb_wb_en  input  1  WB instruction writes back
- branch_taken  input  1  taken branch resolved in EXE
- mem_busy  input  1  SRAM not ready, MEM stage must hold
- hazard  output  1  stall PC/IF-ID, insert bubble into ID/EXE
- flush  output  1  clear IF/ID and ID/EXE registers
- freeze  output  1  hold all pipeline registers and PC
- sel_src_1  output  2  EXE operand-1 mux: 00 reg file, 01 MEM result, 10 WB result
- sel_src_2  output  2  EXE operand-2 mux, same encoding
- stall_cycles  output  STALL_CNT_W  saturating count of cycles with `hazard` or `freeze`
- timeout_err  output  1  sticky: SRAM busy ≥ MEM_TIMEOUT consecutive cycles

Behaviour:
- Reset (`rst`=0, asynchronous):
  - State RUN; wait_cnt=0, stall_cycles=0, timeout_err=0.
  - `hazard`, `flush`, `freeze` forced 0; `sel_src_*`=00.
  - Release is synchronous to the next rising edge.
- Source matching:
  - m1 = (id_src_1==exe_dest & exe_wb_en) | (id_src_1==mem_dest & mem_wb_en).
  - m2 = same using id_src_2, qualified by id_two_src.
- Raw hazard:
  - fwd_en=0: raw = m1|m2.
  - fwd_en=1: raw only for a load-use match against EXE, i.e. exe_mem_r_en & exe_wb_en & (id_src_1==exe_dest | id_two_src & id_src_2==exe_dest).
- Combinational outputs, zero latency, priority freeze > flush > hazard:
  - freeze = mem_busy.
  - flush = branch_taken & !freeze.
  - hazard = raw & !freeze & !flush.
- Branch during freeze: the branch stays in EXE because the registers hold. `flush` fires in the first cycle `mem_busy` drops, and no pending register is needed.
- Forwarding (fwd_en=1 only, else 00): sel_src_1 = 01 if exe_src_1==mem_dest & mem_wb_en, else 10 if exe_src_1==wb_dest & wb_wb_en, else 00. MEM has priority over WB. sel_src_2 is the same using exe_src_2.
- FSM states RUN and WAIT:
  - RUN→WAIT when mem_busy=1 (wait_cnt←1).
  - WAIT stays while mem_busy=1, with wait_cnt incrementing and saturating at MEM_TIMEOUT.
  - WAIT→RUN when mem_busy=0 (wait_cnt←0).
  - When wait_cnt reaches MEM_TIMEOUT, timeout_err←1 and it stays set until reset. The pipeline keeps freezing; there is no forced release.
- stall_cycles increments on every cycle where hazard|freeze, and saturates at all-ones with no wrap.
- Reset mid-WAIT returns immediately to RUN with freeze=0 even if `mem_busy` is high. `freeze` resumes on the first clocked cycle after release.

Decomposition:
- Shared package/constants file holds:
  - forwarding select encodings FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - REGISTER_FILE_ADDRESS_LEN reuse;
  - FSM state encodings RUN/WAIT.
- One natural sub-module: fwd_select_unit, the combinational per-operand MEM/WB priority compare, instantiated twice.

Test Plan:
- fwd_en=0, exe_dest=3, exe_wb_en=1, id_src_1=3 → hazard=1, stall_cycles +1. Same with id_src_2=3, id_two_src=0 → hazard=0.
- fwd_en=1, exe_mem_r_en=1, exe_dest=5, id_src_2=5, id_two_src=1 → hazard=1 for one cycle. Non-load match → hazard=0 and, next cycle, sel_src_2=01.
- fwd_en=1, exe_src_1=7, mem_dest=7, wb_dest=7, both wb_en → sel_src_1=01. Drop mem_wb_en → sel_src_1=10.
- branch_taken=1 with raw hazard present → flush=1, hazard=0. branch_taken with mem_busy=1 for 3 cycles → freeze=1, flush=0 for 3 cycles, then flush=1.
- mem_busy held 64 cycles (MEM_TIMEOUT=64) → timeout_err=1 at cycle 64 and stays 1 after mem_busy=0. Only rst=0 clears it.
- Assert rst=0 asynchronously mid-WAIT with mem_busy=1 → freeze=0, stall_cycles=0 immediately without a clock edge.
